// File: rtl/dp_controller.sv
// Multi-cycle ARM32 data-processing sequencer: IDLE -> LOAD -> [LOAD_S] -> EXEC -> WB, 4 cycles accept-to-idle (5 with LOAD_S).
// Backpressure: waiting is high only in IDLE; instr_valid outside IDLE is ignored. Macro DP_CTRL_REG_SHIFT_EN enables register-specified shifts.
module dp_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [3:0]  status_in,
    output logic        waiting,
    output logic [3:0]  r_addr_a,
    output logic [3:0]  r_addr_b,
    output logic        en_A,
    output logic        en_B,
    output logic        en_S,
    output logic        en_C,
    output logic        sel_imm,
    output logic [31:0] imm32,
    output logic [1:0]  shift_op,
    output logic [4:0]  shift_amt,
    output logic        shift_reg,
    output logic [3:0]  alu_op,
    output logic        w_en,
    output logic [3:0]  w_addr,
    output logic        load_status,
    output logic        illegal
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOAD_S, S_EXEC, S_WB} state_t;

    localparam logic [3:0] OP_CMP = 4'b1010;

    state_t      r_state, w_next;
    logic [31:0] r_instr_q;
    logic        r_cond_pass;

    logic        w_accept;
    logic        w_reg_shift_enc;
    logic        w_use_rs;
    logic        w_op_ok;
    logic        w_cond_ok;
    logic [63:0] w_imm_dbl;

    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cc)
            4'h0: cond_eval = z;
            4'h1: cond_eval = !z;
            4'h2: cond_eval = c;
            4'h3: cond_eval = !c;
            4'h4: cond_eval = n;
            4'h5: cond_eval = !n;
            4'h6: cond_eval = v;
            4'h7: cond_eval = !v;
            4'h8: cond_eval = c && !z;
            4'h9: cond_eval = !c || z;
            4'hA: cond_eval = (n == v);
            4'hB: cond_eval = (n != v);
            4'hC: cond_eval = !z && (n == v);
            4'hD: cond_eval = z || (n != v);
            4'hE: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign w_accept        = instr_valid && (r_state == S_IDLE);
    assign w_reg_shift_enc = !r_instr_q[25] && r_instr_q[4];
    assign w_cond_ok       = cond_eval(r_instr_q[31:28], status_in);

    always_comb begin
        case (r_instr_q[24:21])
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1010, 4'b1100, 4'b1101, 4'b1111: w_op_ok = 1'b1;
            default:                            w_op_ok = 1'b0;
        endcase
    end

    // Illegal is a pure decode of the held word, so it stays sticky until the next acceptance.
`ifdef DP_CTRL_REG_SHIFT_EN
    assign w_use_rs = w_reg_shift_enc;
    assign illegal  = (r_instr_q[27:26] != 2'b00) || !w_op_ok;
`else
    assign w_use_rs = 1'b0;
    assign illegal  = (r_instr_q[27:26] != 2'b00) || !w_op_ok || w_reg_shift_enc;
`endif

    // Rotating a doubled copy right yields the 32-bit rotate-right in the low half.
    assign w_imm_dbl = {24'd0, r_instr_q[7:0], 24'd0, r_instr_q[7:0]} >> {r_instr_q[11:8], 1'b0};
    assign imm32     = w_imm_dbl[31:0];
    assign shift_op  = r_instr_q[6:5];
    assign shift_amt = r_instr_q[11:7];
    assign alu_op    = r_instr_q[24:21];
    assign w_addr    = r_instr_q[15:12];
    assign r_addr_a  = r_instr_q[19:16];
    assign r_addr_b  = (r_state == S_LOAD_S) ? r_instr_q[11:8] : r_instr_q[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_instr_q   <= 32'd0;
            r_cond_pass <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_instr_q <= instr;
            if (r_state == S_EXEC)
                r_cond_pass <= w_cond_ok;
        end
    end

    always_comb begin
        w_next      = r_state;
        waiting     = 1'b0;
        en_A        = 1'b0;
        en_B        = 1'b0;
        en_S        = 1'b0;
        en_C        = 1'b0;
        sel_imm     = 1'b0;
        shift_reg   = 1'b0;
        w_en        = 1'b0;
        load_status = 1'b0;
        case (r_state)
            S_IDLE: begin
                waiting = 1'b1;
                if (instr_valid)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                en_A   = 1'b1;
                en_B   = 1'b1;
                w_next = w_use_rs ? S_LOAD_S : S_EXEC;
            end
            S_LOAD_S: begin
                en_S   = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                en_C      = 1'b1;
                sel_imm   = r_instr_q[25];
                shift_reg = w_use_rs;
                w_next    = S_WB;
            end
            S_WB: begin
                w_en        = r_cond_pass && (r_instr_q[24:21] != OP_CMP) && !illegal;
                load_status = r_cond_pass && (r_instr_q[20] || (r_instr_q[24:21] == OP_CMP)) && !illegal;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dp_controller.sv
// Randomized and directed bench for dp_controller against a per-instruction behavioural model.
module tb_dp_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  status_in;
    logic        waiting;
    logic [3:0]  r_addr_a, r_addr_b;
    logic        en_A, en_B, en_S, en_C, sel_imm, shift_reg;
    logic [31:0] imm32;
    logic [1:0]  shift_op;
    logic [4:0]  shift_amt;
    logic [3:0]  alu_op, w_addr;
    logic        w_en, load_status, illegal;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef DP_CTRL_REG_SHIFT_EN
    localparam bit RS_EN = 1'b1;
`else
    localparam bit RS_EN = 1'b0;
`endif

    dp_controller dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .status_in(status_in), .waiting(waiting), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_C(en_C), .sel_imm(sel_imm),
        .imm32(imm32), .shift_op(shift_op), .shift_amt(shift_amt), .shift_reg(shift_reg),
        .alu_op(alu_op), .w_en(w_en), .w_addr(w_addr), .load_status(load_status),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            0: return z;         1: return !z;
            2: return c;         3: return !c;
            4: return n;         5: return !n;
            6: return v;         7: return !v;
            8: return c && !z;   9: return !(c && !z);
            10: return n == v;   11: return n != v;
            12: return !z && (n == v);
            13: return !(!z && (n == v));
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [7:0] b, input logic [3:0] rot);
        logic [31:0] v;
        v = {24'd0, b};
        for (int i = 0; i < 2 * rot; i++) v = {v[0], v[31:1]};
        return v;
    endfunction

    function automatic bit m_op_ok(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12, 4'd13, 4'd15};
    endfunction

    // strobe vector: {waiting,en_A,en_B,en_S,en_C,w_en,load_status,shift_reg,sel_imm}
    function automatic logic [8:0] strobes();
        return {waiting, en_A, en_B, en_S, en_C, w_en, load_status, shift_reg, sel_imm};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where waiting is back.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] flags);
        bit rs, ill, pass, we, ls;
        int exec_c, wb_c, last_c;
        logic [8:0] exp_v;
        rs     = RS_EN && !ins[25] && ins[4];
        ill    = (ins[27:26] != 2'b00) || !m_op_ok(ins[24:21]) || (!RS_EN && !ins[25] && ins[4]);
        pass   = m_cond(ins[31:28], flags);
        we     = pass && !ill && (ins[24:21] != 4'd10);
        ls     = pass && !ill && (ins[20] || ins[24:21] == 4'd10);
        exec_c = rs ? 3 : 2;
        wb_c   = exec_c + 1;
        last_c = wb_c + 1;
        instr       = ins;
        instr_valid = 1'b1;
        status_in   = flags;
        @(posedge clk);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            exp_v = {c == last_c, c == 1, c == 1, rs && c == 2, c == exec_c,
                     we && c == wb_c, ls && c == wb_c, rs && c == exec_c, ins[25] && c == exec_c};
            chk($sformatf("strobes c%0d i=%h", c, ins), 32'(strobes()), 32'(exp_v));
            if (c == 1) begin
                chk("r_addr_a", 32'(r_addr_a), 32'(ins[19:16]));
                chk("r_addr_b", 32'(r_addr_b), 32'(ins[3:0]));
                chk($sformatf("illegal i=%h", ins), 32'(illegal), 32'(ill));
            end
            if (c == 2 && rs)
                chk("r_addr_b_rs", 32'(r_addr_b), 32'(ins[11:8]));
            if (c == exec_c) begin
                chk("alu_op", 32'(alu_op), 32'(ins[24:21]));
                chk("shift_op", 32'(shift_op), 32'(ins[6:5]));
                chk("shift_amt", 32'(shift_amt), 32'(ins[11:7]));
                chk($sformatf("imm32 i=%h", ins), imm32, m_imm(ins[7:0], ins[11:8]));
            end
            if (c == wb_c)
                chk("w_addr", 32'(w_addr), 32'(ins[15:12]));
            if (c == last_c) begin
                chk("illegal_hold", 32'(illegal), 32'(ill));
                instr_valid = 1'b0;
            end else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  legal_ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12, 4'd13, 4'd15};
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
        w[27:26] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if ($urandom_range(0, 5) != 0) w[24:21] = legal_ops[$urandom_range(0, 8)];
        return w;
    endfunction

    initial begin
        rst_n       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        status_in   = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset strobes", 32'(strobes()), 32'h100);
        chk("reset addr", {r_addr_a, r_addr_b, w_addr}, 32'd0);
        chk("reset imm32", imm32, 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(32'hE3A03005, 4'b0000);
        run_instr(32'h02811008, 4'b0000);
        run_instr(32'h02811008, 4'b0100);
        run_instr(32'hE1500001, 4'b0000);
        run_instr(32'hE3A004FF, 4'b0000);
        run_instr(32'hE0E00000, 4'b0000);
        run_instr(32'hE3A01007, 4'b0000);
        run_instr(32'hE4000000, 4'b0000);
        run_instr(32'hE0822110, 4'b0000);
        run_instr(32'hE0811002, 4'b1111);

        for (int k = 0; k < 80; k++)
            run_instr(rand_instr(), 4'($urandom));

        // Abort an ADD during EXEC: nothing may be written after release.
        instr       = 32'hE0811002;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset en_C", 32'(en_C), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort strobes", 32'(strobes()), 32'h100);
        chk("abort addr", {r_addr_a, r_addr_b, w_addr}, 32'd0);
        chk("abort alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post-abort c%0d", c), 32'(strobes()), 32'h100);
        end
        run_instr(32'hE0811002, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
